// File: rtl/eee_msg_reader.sv
// -----------------------------------------------------------------------------
// eee_msg_reader
//
// Hardware consumer of the image processor's CPU message FIFO. Acts as an
// Avalon-MM master on the processor's slave port: it polls the FIFO fill level
// and pops 7-word "RBY" messages: header, then the red, blue and yellow boxes
// as {min, max} corner words. The three parsed boxes are presented as
// registered outputs that update together, with a one-cycle box_valid strobe.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              0 = finish the current word/message, then hold in IDLE
//   m_chipselect        asserted with m_read or m_write
//   m_read              one-cycle read strobe (never two cycles in a row)
//   m_write             write strobe (flush only)
//   m_address[2:0]      0 = status, 1 = message word
//   m_writedata[31:0]   write data (flush command)
//   m_readdata[31:0]    slave read data, valid the cycle after m_read
//   box_valid           one-cycle pulse when the box outputs update
//   box_{r,b,y}_{min,max}[21:0]  {x[10:0], y[10:0]} corners
//   box_present[2:0]    {yellow, blue, red}: min x <= max x
//   sync_err_count[7:0] saturating count of header mismatches
//
// Build option: define FLUSH_ON_ERR_EN to flush the FIFO (write 32'h10 to
// address 0) on a header mismatch instead of hunting word by word for the
// next header. Without it, m_write and m_writedata are tied to 0.
// -----------------------------------------------------------------------------
module eee_msg_reader #(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter logic [31:0] MSG_ID        = 32'h0052_4259,
    parameter int unsigned MSG_WORDS     = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        box_valid,
    output logic [21:0] box_r_min,
    output logic [21:0] box_r_max,
    output logic [21:0] box_b_min,
    output logic [21:0] box_b_max,
    output logic [21:0] box_y_min,
    output logic [21:0] box_y_max,
    output logic [2:0]  box_present,
    output logic [7:0]  sync_err_count
);

    localparam int unsigned     PCW         = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [PCW-1:0]  POLL_RELOAD = PCW'(POLL_INTERVAL - 1);
    localparam logic [2:0]      LAST_IDX    = 3'(MSG_WORDS - 1);
    localparam logic [7:0]      MSG_LEN     = 8'(MSG_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STATUS,
        S_CAP_STATUS,
        S_RD_WORD,
        S_CAP_WORD,
        S_FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [PCW-1:0]   poll_q, poll_d;
    logic [7:0]       rem_q, rem_d;
    logic [2:0]       idx_q, idx_d;
    logic             in_msg_q, in_msg_d;
    // Words 1..5 are held here until word 6 arrives so outputs never tear.
    logic [4:0][21:0] shad_q, shad_d;
    // Output boxes: [0]=r_min [1]=r_max [2]=b_min [3]=b_max [4]=y_min [5]=y_max
    logic [5:0][21:0] boxes_q, boxes_d;
    logic [2:0]       present_q, present_d;
    logic             valid_q, valid_d;
    logic [7:0]       err_q, err_d;
    logic             msg_done;
`ifdef FLUSH_ON_ERR_EN
    logic             flush_req;
`endif

    function automatic logic [21:0] corner(input logic [31:0] w);
        return {w[26:16], w[10:0]};
    endfunction

    always_comb begin
        state_d      = state_q;
        poll_d       = poll_q;
        rem_d        = rem_q;
        idx_d        = idx_q;
        in_msg_d     = in_msg_q;
        shad_d       = shad_q;
        boxes_d      = boxes_q;
        present_d    = present_q;
        valid_d      = 1'b0;
        err_d        = err_q;
        msg_done     = 1'b0;
        m_chipselect = 1'b0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = 3'd0;
        m_writedata  = 32'h0;
`ifdef FLUSH_ON_ERR_EN
        flush_req    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // Counter parks at 0 while disabled so re-enabling polls at once.
                if (poll_q == '0) begin
                    if (enable) state_d = S_RD_STATUS;
                end else begin
                    poll_d = poll_q - PCW'(1);
                end
            end

            S_RD_STATUS: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                m_address    = 3'd0;
                state_d      = S_CAP_STATUS;
            end

            S_CAP_STATUS: begin
                rem_d = m_readdata[15:8];
                // A partial message resumes on any non-empty FIFO; a fresh one
                // waits until a whole message is available. Never read empty.
                if ((in_msg_q && m_readdata[15:8] != 8'd0) ||
                    (enable && m_readdata[15:8] >= MSG_LEN)) begin
                    state_d = S_RD_WORD;
                end else begin
                    poll_d  = POLL_RELOAD;
                    state_d = S_IDLE;
                end
            end

            S_RD_WORD: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                m_address    = 3'd1;
                rem_d        = rem_q - 8'd1;
                state_d      = S_CAP_WORD;
            end

            S_CAP_WORD: begin
                if (idx_q == 3'd0) begin
                    if (m_readdata == MSG_ID) begin
                        in_msg_d = 1'b1;
                        idx_d    = 3'd1;
                    end else begin
                        err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
`ifdef FLUSH_ON_ERR_EN
                        flush_req = 1'b1;
`endif
                    end
                end else if (idx_q == LAST_IDX) begin
                    boxes_d[4:0] = shad_q;
                    boxes_d[5]   = corner(m_readdata);
                    for (int c = 0; c < 3; c++) begin
                        present_d[c] = boxes_d[2*c][21:11] <= boxes_d[2*c+1][21:11];
                    end
                    valid_d  = 1'b1;
                    in_msg_d = 1'b0;
                    idx_d    = 3'd0;
                    msg_done = 1'b1;
                end else begin
                    shad_d[idx_q - 3'd1] = corner(m_readdata);
                    idx_d                = idx_q + 3'd1;
                end

                // Mid-message: keep reading, re-polling if the FIFO ran dry.
                // Otherwise (done or hunting) stop when empty, disabled, or
                // when too few words remain for another full message.
                if (in_msg_d) begin
                    state_d = (rem_q == 8'd0) ? S_RD_STATUS : S_RD_WORD;
                end else if (rem_q == 8'd0 || !enable || (msg_done && rem_q < MSG_LEN)) begin
                    poll_d  = POLL_RELOAD;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD_WORD;
                end
`ifdef FLUSH_ON_ERR_EN
                if (flush_req) begin
                    poll_d  = poll_q;
                    state_d = S_FLUSH;
                end
`endif
            end

`ifdef FLUSH_ON_ERR_EN
            S_FLUSH: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd0;
                m_writedata  = 32'h10;
                rem_d        = 8'd0;
                idx_d        = 3'd0;
                in_msg_d     = 1'b0;
                poll_d       = POLL_RELOAD;
                state_d      = S_IDLE;
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            poll_q    <= POLL_RELOAD;
            rem_q     <= 8'd0;
            idx_q     <= 3'd0;
            in_msg_q  <= 1'b0;
            shad_q    <= '0;
            boxes_q   <= '0;
            present_q <= 3'd0;
            valid_q   <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            in_msg_q  <= in_msg_d;
            shad_q    <= shad_d;
            boxes_q   <= boxes_d;
            present_q <= present_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign box_valid      = valid_q;
    assign box_r_min      = boxes_q[0];
    assign box_r_max      = boxes_q[1];
    assign box_b_min      = boxes_q[2];
    assign box_b_max      = boxes_q[3];
    assign box_y_min      = boxes_q[4];
    assign box_y_max      = boxes_q[5];
    assign box_present    = present_q;
    assign sync_err_count = err_q;

endmodule

// File: tb/tb_eee_msg_reader.sv
// -----------------------------------------------------------------------------
// tb_eee_msg_reader: directed, table-driven bench for eee_msg_reader with a
// small behavioural model of the image processor's message FIFO slave.
// -----------------------------------------------------------------------------
module tb_eee_msg_reader;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        m_chipselect, m_read, m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'h0;
    logic        box_valid;
    logic [21:0] box_r_min, box_r_max, box_b_min, box_b_max, box_y_min, box_y_max;
    logic [2:0]  box_present;
    logic [7:0]  sync_err_count;

    always #5 clk = ~clk;

    eee_msg_reader #(.POLL_INTERVAL(P)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .box_valid(box_valid),
        .box_r_min(box_r_min), .box_r_max(box_r_max),
        .box_b_min(box_b_min), .box_b_max(box_b_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max),
        .box_present(box_present), .sync_err_count(sync_err_count)
    );

    logic [5:0][21:0] obox;
    assign obox = {box_y_max, box_y_min, box_b_max, box_b_min, box_r_max, box_r_min};

    // ---------------- slave model: status sizes and words are separate queues
    logic [31:0] fifo[$];
    logic [7:0]  stat_q[$];
    int          writes = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [2:0]  last_waddr = 3'h7;

    always @(posedge clk) begin
        if (m_chipselect && m_read) begin
            if (m_address == 3'd0) begin
                if (stat_q.size() > 0) m_readdata <= {16'h0, stat_q.pop_front(), 8'h0};
                else                   m_readdata <= 32'h0;
            end else begin
                if (fifo.size() > 0) m_readdata <= fifo.pop_front();
                else                 m_readdata <= 32'hDEAD_0000;
            end
        end
        if (m_chipselect && m_write) begin
            writes     <= writes + 1;
            last_wdata <= m_writedata;
            last_waddr <= m_address;
            if (m_address == 3'd0 && m_writedata == 32'h10) fifo.delete();
        end
    end

    // ---------------- monitor, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  poll_cnt = 0, wrd_cnt = 0, bv_cnt = 0, bv_lat = 0, last_poll = 0;
    int  rd_twice = 0, partial_err = 0;
    int  poll_times[$];
    logic prev_rd = 1'b0;
    logic [5:0][21:0] prev_box = '0;
    logic [2:0] prev_pres = 3'd0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_rd   <= 1'b0;
            prev_box  <= obox;
            prev_pres <= box_present;
        end else begin
            if (m_read && prev_rd) rd_twice <= rd_twice + 1;
            prev_rd <= m_read;
            if (m_read && m_address == 3'd0) begin
                poll_cnt  <= poll_cnt + 1;
                last_poll <= cyc;
                poll_times.push_back(cyc);
            end
            if (m_read && m_address == 3'd1) wrd_cnt <= wrd_cnt + 1;
            if (box_valid) begin
                bv_cnt <= bv_cnt + 1;
                bv_lat <= cyc - last_poll;
            end
            if (!box_valid && (obox != prev_box || box_present != prev_pres))
                partial_err <= partial_err + 1;
            prev_box  <= obox;
            prev_pres <= box_present;
        end
    end

    // ---------------- checking helpers
    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_bv(input int target, input string name);
        int n = 0;
        while (bv_cnt < target && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_box_valid_count"}, 64'(bv_cnt), 64'(target));
    endtask

    typedef struct {
        logic [6:0][31:0] w;    // w[0] is the header
        logic [5:0][21:0] b;    // r_min, r_max, b_min, b_max, y_min, y_max
        logic [2:0]       pres;
    } vec_t;

    vec_t tbl[3];

    function automatic logic [21:0] xy(input int x, input int y);
        return {11'(x), 11'(y)};
    endfunction

    task automatic push_msg(input logic [6:0][31:0] w);
        for (int i = 0; i < 7; i++) fifo.push_back(w[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pc, n, err0, w0;
        bit found;

        // Test-plan message. Yellow min x=500 exceeds max x=480, so only
        // red and blue count as present.
        tbl[0].w    = {32'h01E000A0, 32'h01F400F0, 32'h01000040, 32'h00C80020,
                       32'h00640080, 32'h00050010, 32'h00524259};
        tbl[0].b    = {xy(480,160), xy(500,240), xy(256,64), xy(200,32), xy(100,128), xy(5,16)};
        tbl[0].pres = 3'b011;
        // Red absent: min x=639 > max x=0.
        tbl[1].w    = {32'h00200020, 32'h00100010, 32'h01000040, 32'h00C80020,
                       32'h00000000, 32'h027F01DF, 32'h00524259};
        tbl[1].b    = {xy(32,32), xy(16,16), xy(256,64), xy(200,32), xy(0,0), xy(639,479)};
        tbl[1].pres = 3'b110;
        // Don't-care bits set, full-scale coordinates, equal x counts as present.
        tbl[2].w    = {32'h00030005, 32'h00030002, 32'h00000000, 32'h00010000,
                       32'h07FF07FF, 32'hFFF8F800, 32'h00524259};
        tbl[2].b    = {xy(3,5), xy(3,2), xy(0,0), xy(1,0), xy(2047,2047), xy(2040,0)};
        tbl[2].pres = 3'b101;

        // ---- reset state
        #2;
        check("rst_m_read", m_read, 0);
        check("rst_m_chipselect", m_chipselect, 0);
        check("rst_m_write", m_write, 0);
        check("rst_box_valid", box_valid, 0);
        check("rst_box_r_min", box_r_min, 0);
        check("rst_box_present", box_present, 0);
        check("rst_sync_err", sync_err_count, 0);
        #20;
        reset_n = 1'b1;
        enable  = 1'b1;

        // ---- under-sized FIFO: no word reads, polls POLL_INTERVAL+2 apart
        stat_q.push_back(8'd3);
        stat_q.push_back(8'd3);
        n = 0;
        while (poll_cnt < 3 && n < 200) begin @(posedge clk); #1; n++; end
        check("poll_count_reached", 64'(poll_cnt >= 3), 1);
        if (poll_times.size() >= 3) begin
            check("poll_gap_1", 64'(poll_times[1] - poll_times[0]), 64'(P + 2));
            check("poll_gap_2", 64'(poll_times[2] - poll_times[1]), 64'(P + 2));
        end
        check("no_word_reads", 64'(wrd_cnt), 0);

        // ---- table of complete messages
        for (int i = 0; i < 3; i++) begin
            base = bv_cnt;
            stat_q.push_back(8'd7);
            push_msg(tbl[i].w);
            wait_bv(base + 1, $sformatf("vec%0d", i));
            for (int j = 0; j < 6; j++)
                check($sformatf("vec%0d_box%0d", i, j), obox[j], tbl[i].b[j]);
            check($sformatf("vec%0d_present", i), box_present, tbl[i].pres);
            check($sformatf("vec%0d_latency", i), 64'(bv_lat), 16);
        end

`ifndef FLUSH_ON_ERR_EN
        // ---- hunt: one bad word then a good message, status 8
        err0 = sync_err_count;
        base = bv_cnt;
        stat_q.push_back(8'd8);
        fifo.push_back(32'h00000001);
        push_msg(tbl[0].w);
        wait_bv(base + 1, "hunt");
        check("hunt_sync_err", sync_err_count, 64'(err0 + 1));
        check("hunt_r_max", box_r_max, tbl[0].b[1]);

        // ---- split: FIFO dries up mid-message, re-poll finishes it
        err0 = sync_err_count;
        base = bv_cnt;
        stat_q.push_back(8'd7);
        stat_q.push_back(8'd4);
        fifo.push_back(32'h00000002);
        fifo.push_back(32'h00000003);
        fifo.push_back(32'h00524258);
        push_msg(tbl[1].w);
        wait_bv(base + 1, "split");
        check("split_sync_err", sync_err_count, 64'(err0 + 3));
        check("split_r_min", box_r_min, tbl[1].b[0]);
        check("split_y_max", box_y_max, tbl[1].b[5]);
        check("split_present", box_present, tbl[1].pres);
        check("split_stat_consumed", 64'(stat_q.size()), 0);
        check("split_fifo_drained", 64'(fifo.size()), 0);
`endif

        // ---- enable drops mid-message: message completes, then FSM holds
        base = bv_cnt;
        w0   = wrd_cnt;
        stat_q.push_back(8'd14);
        push_msg(tbl[2].w);
        push_msg(tbl[0].w);
        n = 0;
        while (wrd_cnt < w0 + 3 && n < 200) begin @(posedge clk); #1; n++; end
        enable = 1'b0;
        wait_bv(base + 1, "en_drop");
        check("en_drop_y_max", box_y_max, tbl[2].b[5]);
        pc = poll_cnt;
        w0 = wrd_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("en_hold_polls", 64'(poll_cnt), 64'(pc));
        check("en_hold_words", 64'(wrd_cnt), 64'(w0));
        check("en_hold_bv", 64'(bv_cnt), 64'(base + 1));
        stat_q.push_back(8'd7);
        enable = 1'b1;
        wait_bv(base + 2, "en_resume");
        check("en_resume_r_min", box_r_min, tbl[0].b[0]);

`ifdef FLUSH_ON_ERR_EN
        // ---- bad header flushes the FIFO with a single write
        err0 = sync_err_count;
        base = bv_cnt;
        pc   = writes;
        stat_q.push_back(8'd8);
        fifo.push_back(32'h00000001);
        push_msg(tbl[1].w);
        n = 0;
        while (writes == pc && n < 200) begin @(posedge clk); #1; n++; end
        repeat (20) @(posedge clk);
        #1;
        check("flush_writes", 64'(writes - pc), 1);
        check("flush_wdata", last_wdata, 32'h10);
        check("flush_waddr", last_waddr, 0);
        check("flush_sync_err", sync_err_count, 64'(err0 + 1));
        check("flush_no_bv", 64'(bv_cnt), 64'(base));
        stat_q.push_back(8'd7);
        push_msg(tbl[2].w);
        wait_bv(base + 1, "flush_recover");
        check("flush_recover_r_max", box_r_max, tbl[2].b[1]);
`else
        check("no_writes", 64'(writes), 0);
`endif

        // ---- reset asserted during a word read
        stat_q.push_back(8'd7);
        push_msg(tbl[1].w);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk); #1;
            if (m_read && m_address == 3'd1) found = 1'b1;
        end
        check("rst_rd_word_seen", found, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_m_read", m_read, 0);
        check("midrst_m_chipselect", m_chipselect, 0);
        check("midrst_box_r_min", box_r_min, 0);
        check("midrst_box_y_max", box_y_max, 0);
        check("midrst_box_present", box_present, 0);
        check("midrst_sync_err", sync_err_count, 0);
        check("midrst_box_valid", box_valid, 0);
        repeat (3) @(negedge clk);
        fifo.delete();
        stat_q.delete();
        #1;
        reset_n = 1'b1;
        base = bv_cnt;
        stat_q.push_back(8'd7);
        push_msg(tbl[1].w);
        wait_bv(base + 1, "post_rst");
        check("post_rst_r_min", box_r_min, tbl[1].b[0]);
        check("post_rst_present", box_present, tbl[1].pres);
        check("post_rst_sync_err", sync_err_count, 0);

        // ---- whole-run properties
        check("read_never_back_to_back", 64'(rd_twice), 0);
        check("no_partial_update", 64'(partial_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
